// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending dispense path, also used by the
// coin-counting channels.
package vend_pkg;

    localparam int N_REQ_DEFAULT         = 4;
    localparam int VEND_CHG_W            = 4;
    localparam int COIN_UNIT_DEFAULT     = 5;
    localparam int MOTOR_TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPENSE = 3'd1,
        ST_PAYOUT   = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } vend_sched_state_t;

endpackage

// File: rtl/vend_dispense_scheduler_if.sv
// Channel-side request/grant bundle plus the motor and hopper handshakes.
// The master modport is the scheduler; the slave modport is the channels/drivers side.
interface vend_dispense_scheduler_if
    import vend_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int CHG_W = VEND_CHG_W
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_item;
    logic [N_REQ*CHG_W-1:0] req_change;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   motor_on;
    logic                   motor_ack;
    logic                   hopper_pulse;
    logic                   hopper_ready;

    modport master (
        input  req, req_item, req_change, motor_ack, hopper_ready,
        output grant, done, motor_on, hopper_pulse
    );

    modport slave (
        output req, req_item, req_change, motor_ack, hopper_ready,
        input  grant, done, motor_on, hopper_pulse
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Arbitrates vending channels onto one dispense motor and one coin hopper,
// sequencing item drop, coin payout and completion for one sale at a time.
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEFAULT,
    parameter int CHG_W         = VEND_CHG_W,
    parameter int COIN_UNIT     = COIN_UNIT_DEFAULT,
    parameter int MOTOR_TIMEOUT = MOTOR_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    vend_dispense_scheduler_if.master bus,
    output logic                      busy,
    output logic                      fault
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(MOTOR_TIMEOUT);

    vend_sched_state_t state, state_d;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     gnt_idx;
    logic [CHG_W-1:0]  coins;
    logic [CHG_W-1:0]  gnt_change;
    logic [CHG_W-1:0]  gnt_coins;
    logic [TW-1:0]     motor_cnt;
    logic [TW-1:0]     motor_cnt_inc;
    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) gnt_idx = PW'(i);
        end
    end

    assign gnt_change    = bus.req_change[gnt_idx*CHG_W +: CHG_W];
    assign gnt_coins     = CHG_W'(int'(gnt_change) / COIN_UNIT);
    assign motor_cnt_inc = motor_cnt + TW'(1);

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    if (bus.req_item[gnt_idx])  state_d = ST_DISPENSE;
                    else if (gnt_coins != '0)   state_d = ST_PAYOUT;
                    else                        state_d = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                // An ack on the limit cycle wins over the timeout.
                if (bus.motor_ack)                     state_d = (coins != '0) ? ST_PAYOUT : ST_DONE;
                else if (motor_cnt_inc == TIMEOUT_LIMIT) state_d = ST_FAULT;
            end
            ST_PAYOUT: if (bus.hopper_ready) state_d = ST_GAP;
            ST_GAP:    state_d = (coins != '0) ? ST_PAYOUT : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            owner            <= '0;
            coins            <= '0;
            motor_cnt        <= '0;
            bus.grant        <= '0;
            bus.done         <= '0;
            bus.motor_on     <= 1'b0;
            bus.hopper_pulse <= 1'b0;
            busy             <= 1'b0;
            fault            <= 1'b0;
        end else begin
            state <= state_d;
            // NOTE: level outputs are registered from state_d so they align with
            // the state they describe instead of trailing it by a cycle.
            busy             <= (state_d != ST_IDLE);
            fault            <= (state_d == ST_FAULT);
            bus.motor_on     <= (state_d == ST_DISPENSE);
            bus.hopper_pulse <= (state == ST_PAYOUT) && bus.hopper_ready;
            bus.grant        <= (state == ST_IDLE) ? arb_gnt : '0;
            bus.done         <= (state == ST_DONE) ? (N_REQ'(1) << owner) : '0;

            if (state == ST_IDLE && arb_any) begin
                owner     <= gnt_idx;
                coins     <= gnt_coins;
                motor_cnt <= '0;
            end
            if (state == ST_DISPENSE) motor_cnt <= motor_cnt_inc;
            if (state == ST_PAYOUT && bus.hopper_ready) coins <= coins - CHG_W'(1);
            if (state == ST_DONE) rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
        end
    end

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Self-checking bench for vend_dispense_scheduler: directed scenarios plus
// randomized sales compared against a transaction-level reference model.
module tb_vend_dispense_scheduler;

    localparam int N  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic fault;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;

    int         obs_motor, obs_pulses, obs_b2b, obs_first_pulse, obs_last_motor;
    int         obs_done_off, obs_fault_off, obs_extra_grant;
    logic [3:0] obs_done;
    logic       obs_busy_done, obs_motor_at_fault, obs_busy_at_fault;

    vend_dispense_scheduler_if #(.N_REQ(N), .CHG_W(CW)) bus ();

    vend_dispense_scheduler #(
        .N_REQ(N), .CHG_W(CW), .COIN_UNIT(5), .MOTOR_TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round-robin reference: first requesting channel at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic do_reset();
        bus.req = '0; bus.req_item = '0; bus.req_change = '0;
        bus.motor_ack = 1'b0; bus.hopper_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " grant"},  bus.grant, 0);
        check({tag, " done"},   bus.done, 0);
        check({tag, " motor"},  bus.motor_on, 0);
        check({tag, " pulse"},  bus.hopper_pulse, 0);
        check({tag, " busy"},   busy, 0);
        check({tag, " fault"},  fault, 0);
    endtask

    // One sale from request to done (or fault). ack_delay: motor cycles before ack,
    // 0 = never. ready_lo: hopper_ready low for that many cycles after grant, <0 = random.
    task automatic run_txn(input string tag, input logic [3:0] mask, input logic [3:0] items,
                           input logic [15:0] chg, input int ack_delay, input int ready_lo);
        int   w, coins, exp_motor, prev_pulse;
        logic item, expect_fault, finished;
        w            = pick(mask, model_ptr);
        item         = items[w];
        coins        = int'(chg[w*4 +: 4]) / 5;
        expect_fault = item && (ack_delay < 1 || ack_delay > 15);
        exp_motor    = item ? ack_delay : 0;
        obs_motor = 0; obs_pulses = 0; obs_b2b = 0; obs_first_pulse = -1; obs_last_motor = -1;
        obs_done = '0; obs_done_off = -1; obs_fault_off = -1; obs_extra_grant = 0;
        obs_busy_done = 1'b1; obs_motor_at_fault = 1'b1; obs_busy_at_fault = 1'b0;
        prev_pulse = -10; finished = 1'b0;

        bus.req = mask; bus.req_item = items; bus.req_change = chg;
        bus.motor_ack = 1'b0; bus.hopper_ready = 1'b1;
        @(negedge clk);
        check({tag, " grant"}, bus.grant, 4'b0001 << w);
        bus.req = '0;

        for (int off = 0; off < 300 && !finished; off++) begin
            if (off > 0) @(negedge clk);
            if (off > 0 && bus.grant != '0) obs_extra_grant++;
            if (bus.motor_on) begin
                obs_motor++;
                obs_last_motor = off;
            end
            if (bus.hopper_pulse) begin
                if (prev_pulse == off - 1) obs_b2b++;
                if (obs_first_pulse < 0) obs_first_pulse = off;
                prev_pulse = off;
                obs_pulses++;
            end
            if (bus.done != '0) begin
                obs_done = bus.done; obs_done_off = off; obs_busy_done = busy; finished = 1'b1;
            end else if (fault) begin
                obs_fault_off = off; obs_motor_at_fault = bus.motor_on;
                obs_busy_at_fault = busy; finished = 1'b1;
            end
            bus.motor_ack    = bus.motor_on && (obs_motor == ack_delay);
            bus.hopper_ready = (ready_lo < 0) ? ($urandom_range(3) != 0) : (off >= ready_lo);
        end
        bus.motor_ack = 1'b0;
        bus.hopper_ready = 1'b1;

        check({tag, " ended"}, finished, 1);
        if (expect_fault) begin
            check({tag, " motor cycles"}, obs_motor, 15);
            check({tag, " fault time"}, obs_fault_off, 15);
            check({tag, " motor at fault"}, obs_motor_at_fault, 0);
            check({tag, " busy at fault"}, obs_busy_at_fault, 1);
            check({tag, " no done"}, obs_done, 0);
        end else begin
            check({tag, " motor cycles"}, obs_motor, exp_motor);
            check({tag, " pulses"}, obs_pulses, coins);
            check({tag, " back-to-back pulses"}, obs_b2b, 0);
            check({tag, " done"}, obs_done, 4'b0001 << w);
            check({tag, " busy at done"}, obs_busy_done, 0);
            check({tag, " extra grants"}, obs_extra_grant, 0);
            if (item && coins > 0)
                check({tag, " item before coins"}, obs_first_pulse > obs_last_motor, 1);
            if (ready_lo == 0)
                check({tag, " done latency"}, obs_done_off, exp_motor + 2 * coins + 1);
            model_ptr = (w + 1) % N;
        end
    endtask

    initial begin
        int         w, seen, last_g, g_cnt;
        logic [3:0] prev_grant;
        logic       saw_done;

        do_reset();
        check_idle("reset");

        // Channel 2: item, change 10 (two coins), ack in third motor cycle.
        run_txn("ch2 sale", 4'b0100, 4'b0100, 16'h0A00, 3, 0);

        // Change 7, no item: one coin; hopper not ready for 5 cycles.
        run_txn("chg7", 4'b0001, 4'b0000, 16'h0007, 0, 5);
        check("chg7 pulse delay", obs_first_pulse, 6);

        // Ack on the very cycle the timeout is reached.
        run_txn("ack at limit", 4'b0010, 4'b0010, 16'h00A0, 15, 0);
        check("ack at limit no fault", fault, 0);

        // Reset while paying out with two coins left.
        bus.req = 4'b0100; bus.req_item = '0; bus.req_change = 16'h0F00; bus.hopper_ready = 1'b1;
        @(negedge clk);
        check("mid reset grant", bus.grant, 4'b0100);
        bus.req = '0;
        @(negedge clk);
        check("mid reset first pulse", bus.hopper_pulse, 1);
        bus.hopper_ready = 1'b0;
        @(negedge clk);
        check("mid reset waiting", bus.hopper_pulse, 0);
        check("mid reset busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid reset");
        reset = 1'b0;
        bus.hopper_ready = 1'b1;
        model_ptr = 0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done != '0) saw_done = 1'b1;
        end
        check("mid reset no done", saw_done, 0);
        run_txn("after reset", 4'b1010, 4'b0000, 16'h0000, 0, 0);

        // Channels 0, 1, 3 requesting continuously with zero-cost sales.
        do_reset();
        bus.req = 4'b1011;
        seen = 0; last_g = -1; prev_grant = '0;
        for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
            @(negedge clk);
            if (prev_grant != '0) check("rotate done", bus.done, prev_grant);
            prev_grant = bus.grant;
            if (bus.grant != '0) begin
                w = pick(4'b1011, model_ptr);
                check($sformatf("rotate grant %0d", seen), bus.grant, 4'b0001 << w);
                if (last_g >= 0) check("rotate spacing", cyc - last_g, 2);
                last_g = cyc;
                model_ptr = (w + 1) % N;
                seen++;
            end
        end
        bus.req = '0;
        check("rotate count", seen, 4);
        @(negedge clk);
        check("rotate last done", bus.done, prev_grant);
        @(negedge clk);

        // Motor never acknowledges: timeout fault, then requests are locked out.
        run_txn("timeout", 4'b0001, 4'b0001, 16'h0000, 0, 0);
        bus.req = 4'b0110;
        g_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.grant != '0) g_cnt++;
        end
        check("fault lockout grants", g_cnt, 0);
        check("fault sticky", fault, 1);
        check("fault busy", busy, 1);
        check("fault motor off", bus.motor_on, 0);
        do_reset();
        check_idle("fault reset");

        // Randomized sales.
        for (int i = 0; i < 40; i++) begin
            run_txn($sformatf("rnd%0d", i), 4'($urandom_range(1, 15)), 4'($urandom),
                    16'($urandom), $urandom_range(1, 15), (i % 4 == 0) ? 0 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
